// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the byte-wide master and its beat counter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_STREAM = 3'd2,
    ST_LAST   = 3'd3,
    ST_ERR    = 3'd4
  } mst_state_t;

  // Byte address of the following beat; the 3-bit space wraps 7 -> 0.
  function automatic logic [2:0] addr_next(input logic [2:0] addr);
    return addr + 3'd1;
  endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Wrapping beat address and remaining-beat counter for one incrementing burst.
module ahb_beat_counter
  import ahb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] start_addr_i,
  input  logic [3:0] len_i,
  input  logic       advance_i,
  output logic [2:0] addr_o,
  output logic       last_o
);

  logic [2:0] addr_q;
  logic [3:0] remain_q;

  // Load on command accept, step once per completed address phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= 3'd0;
      remain_q <= 4'd0;
    end else if (load_i) begin
      addr_q   <= start_addr_i;
      remain_q <= len_i;
    end else if (advance_i) begin
      addr_q <= addr_next(addr_q);
      if (remain_q != 4'd0) begin
        remain_q <= remain_q - 4'd1;
      end else begin
        remain_q <= remain_q;
      end
    end else begin
      addr_q   <= addr_q;
      remain_q <= remain_q;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == 4'd0);

endmodule

// File: rtl/ahb_master_ctrl.sv
// Command-driven AHB-Lite byte master with pipelined address/data phases and error abort.
// Define AHB_MASTER_BUSY_EN to fill write-data gaps with BUSY instead of IDLE + NONSEQ restart.
module ahb_master_ctrl
  import ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic [2:0] haddr,
  output logic [1:0] htrans,
  output logic       hwrite,
  output logic [2:0] hsize,
  output logic [7:0] hwdata,
  input  logic [7:0] hrdata,
  input  logic       hready,
  input  logic       hresp
);

`ifdef AHB_MASTER_BUSY_EN
  localparam logic    RESTART_EN = 1'b0;
  localparam htrans_t GAP_TRANS  = HTRANS_BUSY;
`else
  localparam logic    RESTART_EN = 1'b1;
  localparam htrans_t GAP_TRANS  = HTRANS_IDLE;
`endif

  mst_state_t state_q;
  logic       write_q, restart_q, dphase_q, done_q, err_q, rd_valid_q;
  logic [7:0] hwdata_q, rd_data_q;
  logic [2:0] cnt_addr_s;
  logic       cnt_last_s, load_s, beat_ok_s, addr_act_s, addr_done_s, err_hit_s;
  htrans_t    htrans_s;

  ahb_beat_counter u_beat_counter (
    .clk_i        (hclk),
    .rst_ni       (hreset_n),
    .load_i       (load_s),
    .start_addr_i (cmd_addr),
    .len_i        (cmd_len),
    .advance_i    (addr_done_s),
    .addr_o       (cnt_addr_s),
    .last_o       (cnt_last_s)
  );

  // A write beat is only offered while its data is present, so the gap code follows wr_valid directly.
  always_comb begin
    beat_ok_s  = !write_q || wr_valid;
    addr_act_s = 1'b0;
    htrans_s   = HTRANS_IDLE;
    case (state_q)
      ST_ADDR: begin
        if (beat_ok_s) begin
          addr_act_s = 1'b1;
          htrans_s   = HTRANS_NONSEQ;
        end else begin
          htrans_s   = HTRANS_IDLE;
        end
      end
      ST_STREAM: begin
        if (beat_ok_s) begin
          addr_act_s = 1'b1;
          htrans_s   = restart_q ? HTRANS_NONSEQ : HTRANS_SEQ;
        end else begin
          htrans_s   = GAP_TRANS;
        end
      end
      default: htrans_s = HTRANS_IDLE;
    endcase
    load_s      = (state_q == ST_IDLE) && cmd_valid;
    addr_done_s = addr_act_s && hready;
    err_hit_s   = dphase_q && (hresp == HRESP_ERROR) && !hready;
  end

  // Burst sequencing, data-phase tracking and registered strobes.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      restart_q  <= 1'b0;
      dphase_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      hwdata_q   <= 8'd0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      if (dphase_q && hready && (hresp == HRESP_OKAY) && !write_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= hrdata;
      end
      if (addr_done_s && write_q) begin
        hwdata_q <= wr_data;
      end
      if (err_hit_s) begin
        dphase_q <= 1'b0;
      end else if (addr_done_s) begin
        dphase_q <= 1'b1;
      end else if (hready) begin
        dphase_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            write_q   <= cmd_write;
            restart_q <= 1'b0;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR, ST_STREAM: begin
          if (err_hit_s) begin
            state_q <= ST_ERR;
          end else if (addr_done_s) begin
            restart_q <= 1'b0;
            state_q   <= cnt_last_s ? ST_LAST : ST_STREAM;
          end else if (!beat_ok_s) begin
            restart_q <= RESTART_EN;
          end
        end
        ST_LAST: begin
          if (err_hit_s) begin
            state_q <= ST_ERR;
          end else if (hready) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_ERR: begin
          if (hready) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = addr_done_s && write_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign haddr     = cnt_addr_s;
  assign htrans    = htrans_s;
  assign hwrite    = write_q;
  assign hsize     = HSIZE_BYTE;
  assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: bursts, wait states, error abort, data gaps and reset.
module tb_ahb_master_ctrl;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, done, err;
  logic [2:0] haddr;
  logic [1:0] htrans;
  logic       hwrite;
  logic [2:0] hsize;
  logic [7:0] hwdata, hrdata;
  logic       hready, hresp;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

`ifdef AHB_MASTER_BUSY_EN
  localparam logic [1:0] GAP_T    = 2'b01;
  localparam logic [1:0] RESUME_T = 2'b11;
`else
  localparam logic [1:0] GAP_T    = 2'b00;
  localparam logic [1:0] RESUME_T = 2'b10;
`endif

  logic [7:0] wdat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [2:0] wadr [4] = '{3'd5, 3'd6, 3'd7, 3'd0};

  ahb_master_ctrl dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_htrans"}, htrans, 2'b00);
    check_eq({tag, "_haddr"}, haddr, 3'd0);
    check_eq({tag, "_hwrite"}, hwrite, 1'b0);
    check_eq({tag, "_hsize"}, hsize, 3'b000);
    check_eq({tag, "_hwdata"}, hwdata, 8'h00);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check_eq({tag, "_wr_ready"}, wr_ready, 1'b0);
    check_eq({tag, "_rd_valid"}, rd_valid, 1'b0);
    check_eq({tag, "_rd_data"}, rd_data, 8'h00);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    hreset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 4'd0;
    wr_data = 8'h00; wr_valid = 1'b0; hrdata = 8'h00; hready = 1'b1; hresp = 1'b0;
    #2;
    check_reset_outs("rst");
    cyc();
    hreset_n = 1'b1;

    // Write burst 5,6,7,0 with no wait states.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_len = 4'd3;
    wr_valid = 1'b1; wr_data = 8'h11;
    #1;
    check_eq("t1_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      cmd_valid = 1'b0; wr_data = wdat[i];
      #1;
      check_eq("t1_htrans", htrans, (i == 0) ? 2'b10 : 2'b11);
      check_eq("t1_haddr", haddr, wadr[i]);
      check_eq("t1_wr_ready", wr_ready, 1'b1);
      check_eq("t1_hwrite", hwrite, 1'b1);
      if (i > 0) check_eq("t1_hwdata", hwdata, wdat[i-1]);
    end
    cyc(); wr_valid = 1'b0; #1;
    check_eq("t1_last_htrans", htrans, 2'b00);
    check_eq("t1_last_hwdata", hwdata, 8'h44);
    check_eq("t1_last_done", done, 1'b0);
    // done cycle; next command presented back-to-back
    cyc();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2; cmd_len = 4'd1;
    #1;
    check_eq("t1_done", done, 1'b1);
    check_eq("t1_err", err, 1'b0);
    check_eq("t1_cmd_ready_back", cmd_ready, 1'b1);

    // Read burst 2,3 with two wait states on the second address phase.
    cyc(); cmd_valid = 1'b0; #1;
    check_eq("t2_htrans0", htrans, 2'b10);
    check_eq("t2_haddr0", haddr, 3'd2);
    check_eq("t2_hwrite", hwrite, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(); hready = 1'b0; hrdata = 8'hA5; #1;
      check_eq("t2_stall_htrans", htrans, 2'b11);
      check_eq("t2_stall_haddr", haddr, 3'd3);
      check_eq("t2_stall_rd_valid", rd_valid, 1'b0);
    end
    cyc(); hready = 1'b1; #1;
    check_eq("t2_htrans1", htrans, 2'b11);
    check_eq("t2_haddr1", haddr, 3'd3);
    cyc(); hrdata = 8'h5A; #1;
    check_eq("t2_rd_valid0", rd_valid, 1'b1);
    check_eq("t2_rd_data0", rd_data, 8'hA5);
    check_eq("t2_last_htrans", htrans, 2'b00);
    cyc();
    hrdata = 8'h00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd1; cmd_len = 4'd2;
    wr_valid = 1'b1; wr_data = 8'hC3;
    #1;
    check_eq("t2_rd_valid1", rd_valid, 1'b1);
    check_eq("t2_rd_data1", rd_data, 8'h5A);
    check_eq("t2_done", done, 1'b1);
    check_eq("t2_err", err, 1'b0);

    // Write burst aborted by a two-cycle ERROR on beat 0's data phase.
    cyc(); cmd_valid = 1'b0; #1;
    check_eq("t3_htrans0", htrans, 2'b10);
    check_eq("t3_haddr0", haddr, 3'd1);
    wr_cnt += int'(wr_ready);
    cyc(); wr_data = 8'h3C; hresp = 1'b1; hready = 1'b0; #1;
    check_eq("t3_err1_hwdata", hwdata, 8'hC3);
    check_eq("t3_err1_wr_ready", wr_ready, 1'b0);
    wr_cnt += int'(wr_ready);
    cyc(); hready = 1'b1; #1;
    check_eq("t3_err2_htrans", htrans, 2'b00);
    check_eq("t3_err2_wr_ready", wr_ready, 1'b0);
    check_eq("t3_err2_done", done, 1'b0);
    wr_cnt += int'(wr_ready);
    cyc();
    hresp = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd6; cmd_len = 4'd2;
    wr_valid = 1'b1; wr_data = 8'h01;
    #1;
    check_eq("t3_done", done, 1'b1);
    check_eq("t3_err", err, 1'b1);
    check_eq("t3_cmd_ready", cmd_ready, 1'b1);
    wr_cnt += int'(wr_ready);
    check_eq("t3_wr_ready_count", wr_cnt, 1);

    // Write burst 6,7,0 with write data missing for three cycles before beat 1.
    cyc(); cmd_valid = 1'b0; #1;
    check_eq("t4_htrans0", htrans, 2'b10);
    check_eq("t4_haddr0", haddr, 3'd6);
    check_eq("t4_wr_ready0", wr_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); wr_valid = 1'b0; #1;
      check_eq("t4_gap_htrans", htrans, GAP_T);
      check_eq("t4_gap_haddr", haddr, 3'd7);
      check_eq("t4_gap_wr_ready", wr_ready, 1'b0);
      check_eq("t4_gap_hwdata", hwdata, 8'h01);
    end
    cyc(); wr_valid = 1'b1; wr_data = 8'h02; #1;
    check_eq("t4_resume_htrans", htrans, RESUME_T);
    check_eq("t4_resume_haddr", haddr, 3'd7);
    check_eq("t4_resume_wr_ready", wr_ready, 1'b1);
    cyc(); wr_data = 8'h03; #1;
    check_eq("t4_beat2_htrans", htrans, 2'b11);
    check_eq("t4_beat2_haddr", haddr, 3'd0);
    check_eq("t4_beat2_hwdata", hwdata, 8'h02);
    cyc(); wr_valid = 1'b0; #1;
    check_eq("t4_last_htrans", htrans, 2'b00);
    check_eq("t4_last_hwdata", hwdata, 8'h03);
    cyc();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd4; cmd_len = 4'd3;
    #1;
    check_eq("t4_done", done, 1'b1);
    check_eq("t4_err", err, 1'b0);

    // Read burst of 4 at address 4, reset asserted during beat 2's address phase.
    cyc(); cmd_valid = 1'b0; hrdata = 8'h77; #1;
    check_eq("t5_htrans0", htrans, 2'b10);
    check_eq("t5_haddr0", haddr, 3'd4);
    cyc(); #1;
    check_eq("t5_haddr1", haddr, 3'd5);
    cyc(); #1;
    check_eq("t5_haddr2", haddr, 3'd6);
    check_eq("t5_rd_valid", rd_valid, 1'b1);
    check_eq("t5_rd_data", rd_data, 8'h77);
    hreset_n = 1'b0;
    #1;
    check_reset_outs("t5_rst");
    #1;
    hreset_n = 1'b1;
    cyc();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd3; cmd_len = 4'd0;
    wr_valid = 1'b1; wr_data = 8'h9E;
    #1;
    check_eq("t5_post_done", done, 1'b0);
    check_eq("t5_post_cmd_ready", cmd_ready, 1'b1);
    cyc(); cmd_valid = 1'b0; #1;
    check_eq("t5_new_htrans", htrans, 2'b10);
    check_eq("t5_new_haddr", haddr, 3'd3);
    check_eq("t5_new_wr_ready", wr_ready, 1'b1);
    check_eq("t5_new_no_done", done, 1'b0);
    cyc(); wr_valid = 1'b0; #1;
    check_eq("t5_new_hwdata", hwdata, 8'h9E);
    check_eq("t5_new_last_htrans", htrans, 2'b00);
    cyc(); #1;
    check_eq("t5_new_done", done, 1'b1);
    check_eq("t5_new_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_ctrl.md
# ahb_master_ctrl

Command-driven AHB-Lite master that generates the pipelined address/control and write-data traffic consumed by the team's 8-bit AHB slave interface. Each command is one incrementing burst of 1–16 byte beats. The block overlaps the address phase of beat N+1 with the data phase of beat N, honours `hready` wait states, and aborts cleanly on a two-cycle `hresp` error. It sits between the local command source and the bus address decoder, directly upstream of the slave interface.

## Interface
- Parameters: none (bus is fixed at 8-bit data, 3-bit address).
- Clock and reset: one clock, `hclk`; reset is `hreset_n`, asynchronous and active-low.
- `hclk` in 1: bus clock, all logic on rising edge.
- `hreset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 3: start byte address.
- `cmd_len` in 4: beats minus one (0 → 1 beat, 15 → 16 beats).
- `wr_data` in 8: next write byte.
- `wr_valid` in 1: `wr_data` available.
- `wr_ready` out 1: `wr_data` consumed this cycle.
- `rd_data` out 8: captured read byte.
- `rd_valid` out 1: one-cycle strobe per read beat.
- `done` out 1: one-cycle strobe at burst end.
- `err` out 1: valid with `done`; 1 if the burst was aborted by `hresp`.
- `haddr` out 3, `htrans` out 2, `hwrite` out 1, `hsize` out 3, `hwdata` out 8: AHB master outputs.
- `hrdata` in 8, `hready` in 1, `hresp` in 1: AHB slave response (`hresp` = 1 means ERROR).

## Operation
- Reset values: `htrans`=IDLE(00), `haddr`=0, `hwrite`=0, `hsize`=000, `hwdata`=0, `cmd_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `done`=0, `err`=0. The state is IDLE.
- `hsize` is always 000 (byte). `haddr` increments by 1 per beat and wraps modulo 8 (7 → 0); the burst continues across the wrap.
- States:
  - IDLE: `cmd_ready`=1. On accept, latch the command and go to ADDR.
  - ADDR: drive NONSEQ with the first beat.
  - STREAM: drive SEQ for beats 2..N.
  - LAST: final data phase, `htrans`=IDLE.
  - ERR: second error cycle.
- An address phase completes on a rising edge with `hready`=1. The next beat's address is presented in the following cycle, or the block moves to LAST after the final beat. `haddr`, `htrans` and `hwrite` are held stable while `hready`=0.
- Write beats:
  - `wr_ready` is asserted in the cycle the beat's address phase completes, which requires `wr_valid`=1.
  - `wr_data` is registered into `hwdata` at that edge and held for the whole data phase, including wait states.
  - If `wr_valid`=0 when a beat is due, see Configuration.
- Read beats: on the edge completing a data phase (`hready`=1, `hresp`=0), `rd_data`←`hrdata` and `rd_valid`=1 for one cycle.
- LAST → IDLE when the final data phase completes. `done`=1 for one cycle. `cmd_ready` returns to 1 in the same cycle as `done`.
- Error handling:
  - `hresp`=1 with `hready`=0 forces `htrans`=IDLE in the next cycle, cancelling any pipelined beat. The block enters ERR.
  - ERR waits for `hready`=1, then returns to IDLE with `done`=1 and `err`=1.
  - No further `rd_valid` or `wr_ready` is issued for the aborted burst.
- `cmd_valid` while busy is ignored, because `cmd_ready`=0. The command fields are sampled only on accept.
- Asserting `hreset_n` low mid-burst returns all outputs to their reset values immediately. No `done` is issued.

## Timing
- Single-beat write with no wait states:
  - Accept at edge 0.
  - NONSEQ at cycle 1.
  - `hwdata` valid at cycle 2.
  - `done` at cycle 3.
- An N-beat burst with no wait states has N consecutive address cycles. `done` is 2 cycles after the last address.
- Each `hready`=0 cycle adds exactly one cycle of latency.
- Back-to-back commands: the new NONSEQ appears in the cycle after `done`.

## Configuration
- `AHB_MASTER_BUSY_EN` defined: when write data is missing mid-burst, the block drives `htrans`=BUSY(01) with the next `haddr` held. It resumes SEQ when `wr_valid`=1. If data is missing before the first beat, the block stays in ADDR with `htrans`=IDLE.
- `AHB_MASTER_BUSY_EN` undefined: missing data mid-burst drives IDLE. When data arrives, the block re-issues the pending beat as NONSEQ at the current address and continues with SEQ.

## Structure
- Shared package `ahb_pkg` holds:
  - the `htrans_t` enum (IDLE, BUSY, NONSEQ, SEQ);
  - the `HSIZE_BYTE` constant;
  - the `hresp` OKAY/ERROR constants;
  - the master state enum.
- One sub-module, `ahb_beat_counter`, owns the wrapping address counter and the remaining-beat counter. It takes load, advance and last outputs.

## Test plan
- Write, addr=5, len=3, data 0x11..0x44, `hready`=1: `haddr` 5,6,7,0 with NONSEQ,SEQ,SEQ,SEQ; `hwdata` 0x11..0x44; `done`=1, `err`=0.
- Read, addr=2, len=1, `hrdata` 0xA5 then 0x5A, with `hready`=0 for 2 cycles on beat 1: `rd_valid` ×2 with 0xA5 and 0x5A; `haddr`=3 held during the stall.
- Write, len=2, slave errors on beat 0 (`hresp`=1/`hready`=0, then `hresp`=1/`hready`=1): `htrans`=IDLE next cycle; `done`=1 with `err`=1; only 1 `wr_ready`.
- Write, len=2, `wr_valid` dropped for 3 cycles before beat 1: `htrans`=BUSY ×3 then SEQ with the macro; without the macro, IDLE ×3 then NONSEQ at addr+1.
- Reset asserted mid-burst at beat 2 of 4: all outputs return to reset values immediately; the next command starts with NONSEQ at its own `cmd_addr`.
